mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port word-addressed ram between two requesters: instruction fetch (IF)
//   and load/store data (D). Converts byte addresses to word indices and drives ram
//   act/ldr/str/address/valin. Runs one access at a time; round-robin when both request.
//   Sits between the cpu control path and the ram instance.
// PARAMETERS
//   ADDR_W     32  byte-address width of requester address ports
//   DATA_W     32  data width (matches ram word)
//   MEM_WORDS  64  ram depth in words; word index >= MEM_WORDS is an error
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active-high
//   if_req      in   1       IF read request; held high until if_done
//   if_addr     in   ADDR_W  IF byte address, stable while if_req high
//   if_done     out  1       one-cycle pulse: IF access complete, rdata/err valid
//   d_req       in   1       D request; held high until d_done
//   d_wr        in   1       1 = store, 0 = load; stable while d_req high
//   d_addr      in   ADDR_W  D byte address, stable while d_req high
//   d_wdata     in   DATA_W  store data, stable while d_req high
//   d_done      out  1       one-cycle pulse: D access complete, rdata/err valid
//   rdata       out  DATA_W  read data; valid only while if_done or d_done (load) high
//   err         out  1       valid with done; 1 = address out of range, no ram access made
//   busy        out  1       high in every state except IDLE
//   ram_act     out  1       ram enable
//   ram_ldr     out  1       ram read strobe
//   ram_str     out  1       ram write strobe
//   ram_addr    out  32      ram word index = addr >> 2
//   ram_valin   out  DATA_W  ram write data
//   ram_valout  in   DATA_W  ram registered read data (valid cycle after act)
// BEHAVIOUR
//   - Reset (async): state=IDLE; rr_last=IF (so D wins first tie); all outputs 0.
//   - States: IDLE -> ISSUE -> RESP -> IDLE. Every access takes exactly 3 cycles.
//   - IDLE: at the edge, if any req is high, choose the winner and register its
//     addr/wr/wdata. Only one requester: it wins. Both requesting: the one not in
//     rr_last wins. rr_last <= winner. No requests: stay in IDLE.
//   - ISSUE (one cycle): ram_addr = latched_addr[ADDR_W-1:2]; low 2 bits are ignored.
//     In range: ram_act=1, ram_ldr=~wr, ram_str=wr, ram_valin=wdata (IF always reads).
//     Out of range (index >= MEM_WORDS): ram_act/ldr/str=0, err flag latched.
//   - RESP (one cycle): winner's done=1; err=latched err; rdata=ram_valout for
//     in-range loads, 0 otherwise. ram_* strobes are 0. Next state is IDLE.
//   - Latency: req sampled at edge E0 (end of IDLE cycle); ISSUE in cycle E0+1; done high
//     in cycle E0+2. The requester must drop req at the edge ending its done cycle. A req
//     still high in IDLE is a new request.
//   - A requester's req rising while another access is in flight is held off until IDLE.
//     It is then arbitrated normally. No request is lost or duplicated.
//   - ram_act/ldr/str are 0 in all states except ISSUE.
//   - if_done and d_done are never high together. done is never asserted without a
//     prior grant.
//   - rst mid-access (any state): immediate return to IDLE with outputs 0. No done is
//     issued for the aborted access. A store in ISSUE may or may not reach ram.
// TESTING
//   1 mem[2]=0x11112222; if_req, if_addr=0x8 -> ram_addr=2, ram_ldr=1 in cycle+1;
//     if_done=1, rdata=0x11112222, err=0 in cycle+2.
//   2 d_req, d_wr=1, d_addr=0x10, d_wdata=0xDEADBEEF -> ram_str=1, ram_addr=4, d_done at +2;
//     then if_req addr 0x10 -> rdata=0xDEADBEEF.
//   3 After reset, if_req and d_req both high continuously (each dropped after its done)
//     -> grant order D, IF, D, IF. done pulses are 3 cycles apart and never overlap.
//   4 d_req load, d_addr=0x100 (word 64) -> ram_act stays 0; d_done=1, err=1, rdata=0.
//   5 if_req addr 0x4, rst pulsed during ISSUE -> all outputs 0 that cycle, no if_done.
//     After rst release, same req completes normally with rdata=mem[1].
//   6 if_addr=0x7 -> ram_addr=1 (low bits ignored); busy=1 for exactly 2 cycles per access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and ram-side bus shared by mem_arbiter and its neighbours.
// The arbiter takes the slave view; the cpu control path and ram take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              ram_act;
    logic              ram_ldr;
    logic              ram_str;
    logic [31:0]       ram_addr;
    logic [DATA_W-1:0] ram_valin;
    logic [DATA_W-1:0] ram_valout;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, ram_valout,
        output if_done, d_done, rdata, err, busy,
        ram_act, ram_ldr, ram_str, ram_addr, ram_valin
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, ram_valout,
        input  if_done, d_done, rdata, err, busy,
        ram_act, ram_ldr, ram_str, ram_addr, ram_valin
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word-addressed ram between
// instruction fetch (IF) and load/store (D); every access is IDLE -> ISSUE -> RESP.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic       {REQ_IF, REQ_D}           req_e;

    state_e            state_q, state_d;
    req_e              rr_last_q, rr_last_d;
    req_e              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    req_e              winner;
    logic [ADDR_W-3:0] word_idx;
    logic              out_of_range;

    assign word_idx     = addr_q[ADDR_W-1:2];
    assign out_of_range = {2'b00, word_idx} >= ADDR_W'(MEM_WORDS);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its _d input, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_last_q <= REQ_IF;
            owner_q   <= REQ_IF;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        winner    = REQ_IF;

        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the requester that did not win last time goes first.
                    if (bus.if_req && bus.d_req)
                        winner = (rr_last_q == REQ_IF) ? REQ_D : REQ_IF;
                    else
                        winner = bus.d_req ? REQ_D : REQ_IF;

                    owner_d   = winner;
                    rr_last_d = winner;
                    if (winner == REQ_D) begin
                        wr_d    = bus.d_wr;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                err_d   = out_of_range;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.if_done   = 1'b0;
        bus.d_done    = 1'b0;
        bus.rdata     = '0;
        bus.err       = 1'b0;
        bus.ram_act   = 1'b0;
        bus.ram_ldr   = 1'b0;
        bus.ram_str   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_valin = '0;

        case (state_q)
            S_ISSUE: begin
                bus.ram_addr  = 32'(word_idx);
                bus.ram_valin = wdata_q;
                // Out-of-range indices never touch the ram; the error is reported in RESP.
                if (!out_of_range) begin
                    bus.ram_act = 1'b1;
                    bus.ram_ldr = ~wr_q;
                    bus.ram_str = wr_q;
                end
            end
            S_RESP: begin
                if (owner_q == REQ_D) bus.d_done  = 1'b1;
                else                  bus.if_done = 1'b1;
                bus.err   = err_q;
                bus.rdata = (!err_q && !wr_q) ? bus.ram_valout : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 64-word
// registered-read ram; expected values are hand-computed constants.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];

    // Registered-read ram: read data appears the cycle after act.
    always @(posedge clk) begin
        if (bus.ram_act) begin
            if (bus.ram_ldr) bus.ram_valout <= mem[bus.ram_addr[5:0]];
            if (bus.ram_str) mem[bus.ram_addr[5:0]] = bus.ram_valin;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete access from an IDLE start; checks ISSUE and RESP cycles.
    task automatic do_access(input string tag, input bit is_d, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_idx, input logic [31:0] exp_rdata,
                             input bit exp_err);
        @(posedge clk); #1;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_issue_addr"}, bus.ram_addr, exp_idx);
        check({tag, "_issue_act"},  32'(bus.ram_act), 32'(!exp_err));
        check({tag, "_issue_ldr"},  32'(bus.ram_ldr), 32'(!exp_err && !wr));
        check({tag, "_issue_str"},  32'(bus.ram_str), 32'(!exp_err && wr));
        check({tag, "_issue_busy"}, 32'(bus.busy), 32'd1);
        if (wr && !exp_err) check({tag, "_issue_valin"}, bus.ram_valin, wdata);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_resp_d_done"},  32'(bus.d_done),  32'(is_d));
        check({tag, "_resp_if_done"}, 32'(bus.if_done), 32'(!is_d));
        check({tag, "_resp_rdata"},   bus.rdata, exp_rdata);
        check({tag, "_resp_err"},     32'(bus.err), 32'(exp_err));
        check({tag, "_resp_act"},     32'(bus.ram_act), 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_done"}, 32'({bus.if_done, bus.d_done}), 32'd0);
    endtask

    int order [4];
    int when  [4];
    int n_done;
    int overlap;
    int busy_cnt;
    bit dd, id, raise_d, raise_i;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[1] = 32'hA5A5_0001;
        mem[2] = 32'h1111_2222;

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0;  bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'({bus.if_done, bus.d_done}), 32'd0);
        check("rst_strb",  32'({bus.ram_act, bus.ram_ldr, bus.ram_str}), 32'd0);
        check("rst_addr",  bus.ram_addr, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        rst = 1'b0;

        // Both requesters contend from reset: expect D, IF, D, IF, 3 cycles apart.
        for (int i = 0; i < 4; i++) begin order[i] = 2; when[i] = 0; end
        n_done = 0; overlap = 0; raise_d = 0; raise_i = 0;
        bus.d_wr = 1'b0; bus.d_addr = 32'h0; bus.if_addr = 32'h4;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.if_req = 1'b1;
        for (int cyc = 0; cyc < 40 && n_done < 4; cyc++) begin
            @(negedge clk);
            dd = bus.d_done; id = bus.if_done;
            if (dd && id) overlap++;
            if (dd)      begin order[n_done] = 1; when[n_done] = cyc; n_done++; end
            else if (id) begin order[n_done] = 0; when[n_done] = cyc; n_done++; end
            @(posedge clk); #1;
            if (raise_d) begin bus.d_req = 1'b1; raise_d = 0; end
            if (raise_i) begin bus.if_req = 1'b1; raise_i = 0; end
            if (dd) begin bus.d_req = 1'b0;  raise_d = (n_done <= 2); end
            if (id) begin bus.if_req = 1'b0; raise_i = (n_done <= 2); end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("rr_count",   32'(n_done), 32'd4);
        check("rr_overlap", 32'(overlap), 32'd0);
        check("rr_order0",  32'(order[0]), 32'd1);
        check("rr_order1",  32'(order[1]), 32'd0);
        check("rr_order2",  32'(order[2]), 32'd1);
        check("rr_order3",  32'(order[3]), 32'd0);
        check("rr_gap01",   32'(when[1] - when[0]), 32'd3);
        check("rr_gap12",   32'(when[2] - when[1]), 32'd3);
        check("rr_gap23",   32'(when[3] - when[2]), 32'd3);

        do_access("if_rd8",   1'b0, 1'b0, 32'h8,   32'h0,         32'd2,  32'h1111_2222, 1'b0);
        do_access("d_st10",   1'b1, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'd4,  32'h0,         1'b0);
        do_access("if_rd10",  1'b0, 1'b0, 32'h10,  32'h0,         32'd4,  32'hDEAD_BEEF, 1'b0);
        do_access("d_ld_top", 1'b1, 1'b0, 32'hFC,  32'h0,         32'd63, 32'h1000_003F, 1'b0);
        do_access("d_ld_oor", 1'b1, 1'b0, 32'h100, 32'h0,         32'd64, 32'h0,         1'b1);

        // Reset pulsed mid-ISSUE: outputs drop at once, the held request restarts.
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_strb", 32'({bus.ram_act, bus.ram_ldr, bus.ram_str}), 32'd0);
        check("rst_mid_addr", bus.ram_addr, 32'd0);
        check("rst_mid_done", 32'(bus.if_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_rec_nodone", 32'(bus.if_done), 32'd0);
        check("rst_rec_addr",   bus.ram_addr, 32'd1);
        check("rst_rec_ldr",    32'(bus.ram_ldr), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rst_rec_done",  32'(bus.if_done), 32'd1);
        check("rst_rec_rdata", bus.rdata, 32'hA5A5_0001);
        check("rst_rec_err",   32'(bus.err), 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Unaligned byte address and busy width.
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h7;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (i == 1) check("unal_addr", bus.ram_addr, 32'd1);
            if (i == 2) begin
                check("unal_done",  32'(bus.if_done), 32'd1);
                check("unal_rdata", bus.rdata, 32'hA5A5_0001);
                @(posedge clk); #1;
                bus.if_req = 1'b0;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
